// File: rtl/button_event_gen_if.sv
// Button event bundle: the debounced level going in and the registered
// event pulses/levels coming out of one button_event_gen instance.
interface button_event_gen_if;
    logic DEBNC_SIGN;
    logic PRESS_PULSE;
    logic RELEASE_PULSE;
    logic LONG_PULSE;
    logic REPEAT_PULSE;
    logic HELD;
    logic LONG_PRESS;

    // Event generator side: consumes the level, produces the events.
    modport master (
        input  DEBNC_SIGN,
        output PRESS_PULSE,
        output RELEASE_PULSE,
        output LONG_PULSE,
        output REPEAT_PULSE,
        output HELD,
        output LONG_PRESS
    );

    // Consumer side: supplies the level, observes the events.
    modport slave (
        output DEBNC_SIGN,
        input  PRESS_PULSE,
        input  RELEASE_PULSE,
        input  LONG_PULSE,
        input  REPEAT_PULSE,
        input  HELD,
        input  LONG_PRESS
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns one debounced button level into registered single-cycle events:
// press, release, long-press and periodic auto-repeat while long-held.
module button_event_gen #(
    parameter bit ACTIVE_HIGH   = 1'b1,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 27
) (
    input  logic                clk,
    input  logic                RST_N,
    button_event_gen_if.master  btn
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    // Terminal counts: the threshold fires on the edge where the counter
    // already sits at N-1, so the event lands exactly N edges after the
    // edge that cleared the counter.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

    // Normalised "pressed" level regardless of button polarity.
    logic act;
    assign act = btn.DEBNC_SIGN ^ ~ACTIVE_HIGH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             long_press_q, long_press_d;

    // State, counter, input sample and all output flops; async clear.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            act_q        <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            repeat_q     <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            repeat_q     <= repeat_d;
            long_press_q <= long_press_d;
        end
    end

    // Next state and hold counter; release has priority over thresholds.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (act && !act_q) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (!act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (!act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!REPEAT_EN) begin
                    // Repeat disabled: counter parks at zero while held.
                    cnt_d = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Event decode from the current state; the conditions are mutually
    // exclusive so at most one pulse is registered per edge.
    always_comb begin
        act_d        = act;
        press_d      = (state_q == IDLE) && act && !act_q;
        release_d    = (state_q != IDLE) && !act;
        long_d       = (state_q == PRESSED) && act && (cnt_q == LONG_LAST);
        repeat_d     = REPEAT_EN && (state_q == LONG_HELD) && act &&
                       (cnt_q == REPEAT_LAST);
        long_press_d = (state_d == LONG_HELD);
    end

    assign btn.PRESS_PULSE   = press_q;
    assign btn.RELEASE_PULSE = release_q;
    assign btn.LONG_PULSE    = long_q;
    assign btn.REPEAT_PULSE  = repeat_q;
    assign btn.HELD          = act_q;
    assign btn.LONG_PRESS    = long_press_q;

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumer side of the one-bit debounce output; one instance per debounced button.
- Turns the clean button level into registered, single-cycle events: press, release, long-press and auto-repeat.
- The LED display control logic uses these events to step digits/modes without edge-detecting raw levels itself.
- Fully synchronous to the system clock, with registered outputs.

Parameters:
- ACTIVE_HIGH, 1, 1 = DEBNC_SIGN high means pressed; 0 = low means pressed.
- LONG_CYCLES, 50000000, continuous-hold cycles from press event to long-press event; must be ≥2.
- REPEAT_CYCLES, 10000000, period of auto-repeat pulses after long-press; 0 disables repeat.
- CNT_W, 27, hold-counter width; must represent max(LONG_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally
- DEBNC_SIGN  in  1  debounced button level, already synchronous to clk
- PRESS_PULSE  out  1  one-cycle pulse on press
- RELEASE_PULSE  out  1  one-cycle pulse on release
- LONG_PULSE  out  1  one-cycle pulse when hold reaches LONG_CYCLES
- REPEAT_PULSE  out  1  one-cycle pulse every REPEAT_CYCLES while long-held
- HELD  out  1  level: button currently pressed (registered)
- LONG_PRESS  out  1  level: long-press threshold reached and button still held

Behaviour:
- Input normalisation: act = DEBNC_SIGN xor ~ACTIVE_HIGH. One sample register act_q; its reset value is 0 (not pressed).
- Reset (RST_N=0, asynchronous): all outputs 0, state IDLE, counter 0, act_q 0.
  - A button held through reset release produces PRESS_PULSE on the first edge after release.
- Edge convention: "edge k" is a rising clk edge. Outputs register at edge k and are visible in the cycle following it. All pulses are exactly 1 cycle wide.
- State machine, states IDLE, PRESSED, LONG_HELD:
  - IDLE:
    - At edge k with act=1 and act_q=0: PRESS_PULSE=1, HELD=1, cnt←0, go to PRESSED.
  - PRESSED:
    - act=1: cnt increments each edge.
    - When cnt = LONG_CYCLES-1 at an edge with act=1: LONG_PULSE=1, LONG_PRESS=1, cnt←0, go to LONG_HELD.
    - Net timing: LONG_PULSE is registered exactly LONG_CYCLES edges after PRESS_PULSE's edge.
  - LONG_HELD:
    - act=1: cnt increments.
    - When cnt = REPEAT_CYCLES-1 and REPEAT_CYCLES≠0: REPEAT_PULSE=1, cnt←0.
    - First repeat is REPEAT_CYCLES edges after LONG_PULSE; repeats continue periodically until release.
  - Any non-IDLE state:
    - At an edge with act=0: RELEASE_PULSE=1, HELD=0, LONG_PRESS=0, cnt←0, go to IDLE.
- Simultaneous events:
  - Release at the same edge the long or repeat threshold would hit: release wins; no LONG_PULSE/REPEAT_PULSE.
  - At most one of PRESS/RELEASE/LONG/REPEAT pulses is high in any cycle.
- Short taps:
  - A 1-cycle press gives PRESS_PULSE then RELEASE_PULSE in consecutive cycles.
  - Re-press on the edge after release gives a new PRESS_PULSE; there is no lockout.
- Counter:
  - Never wraps; cleared on every state change.
  - Holds at 0 in IDLE.
  - In LONG_HELD with REPEAT_CYCLES=0 it holds at 0.
- HELD equals act registered, except it is forced to 0 in reset.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, ACTIVE_HIGH=1):
- Reset:
  - RST_N low mid-cycle while DEBNC_SIGN=1 → all outputs 0 immediately (async).
  - After RST_N high → PRESS_PULSE on first edge, HELD=1.
- Short tap: DEBNC_SIGN high 3 cycles → PRESS_PULSE 1 cycle; HELD 3 cycles; RELEASE_PULSE 1 cycle right after HELD falls; no LONG_PULSE.
- Long hold: hold 20 cycles from press edge t0 → LONG_PULSE at t0+8; REPEAT_PULSE at t0+12, t0+16, t0+20 edge only if still held; LONG_PRESS high t0+8 until release edge.
- Boundary release: release so act=0 at edge t0+8 → RELEASE_PULSE, no LONG_PULSE, LONG_PRESS stays 0.
- Back-to-back: high 2 cycles, low 1 cycle, high 2 cycles → PRESS, RELEASE, PRESS, RELEASE pulses each exactly 1 cycle, none overlapping.
- Polarity/disable: ACTIVE_HIGH=0, REPEAT_CYCLES=0, DEBNC_SIGN low 30 cycles → PRESS_PULSE, LONG_PULSE at +8, zero REPEAT_PULSE, RELEASE_PULSE when DEBNC_SIGN returns high.
